tick_timer_n: RTL and testbench



---
 rtl/tick_timer_pkg.sv | 8 +
 rtl/tick_timer_cnt.sv | 29 ++
 rtl/tick_timer_n.sv | 122 ++++++++++++
 tb/tb_tick_timer_n.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/tick_timer_pkg.sv
// Shared types and constants for the tick_timer_n block.
package tick_timer_pkg;

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} tt_state_t;

    localparam int TICK_CNT_W = 8;

endpackage

// File: rtl/tick_timer_cnt.sv
// n-bit loadable down-counter with zero flag; load has priority over decrement.
module tick_timer_cnt #(
    parameter int n = 5
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         i_load,
    input  logic         i_dec,
    input  logic [n-1:0] i_load_val,
    output logic [n-1:0] o_count,
    output logic         o_zero
);

    logic [n-1:0] r_count;

    // Counter state: clear on reset, load or step down by one
    always_ff @(posedge clk_i) begin
        if (rst_i)
            r_count <= '0;
        else if (i_load)
            r_count <= i_load_val;
        else if (i_dec)
            r_count <= r_count - 1'b1;
    end

    assign o_count = r_count;
    assign o_zero  = (r_count == '0);

endmodule

// File: rtl/tick_timer_n.sv
// Programmable down-counting tick generator (periodic / one-shot).
// Optional tick pulse counter output enabled by defining TICK_TIMER_TICKCNT_EN.
module tick_timer_n
    import tick_timer_pkg::*;
#(
    parameter int         n          = 5,
    parameter logic [n-1:0] RST_PERIOD = 31
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic [n-1:0] period_i,
    input  logic         start_i,
    input  logic         stop_i,
    input  logic         mode_i,
    output logic         tick_o,
    output logic         busy_o,
`ifdef TICK_TIMER_TICKCNT_EN
    output logic [TICK_CNT_W-1:0] tick_cnt_o,
`endif
    output logic [n-1:0] count_o
);

    tt_state_t    r_state;
    logic [n-1:0] r_period;
    logic         r_mode;

    logic         w_cnt_load;
    logic         w_cnt_dec;
    logic [n-1:0] w_cnt_val;
    logic [n-1:0] w_count;
    logic         w_zero;
    logic [n-1:0] w_start_period;
    logic         w_start_acc;

    // A start in the same cycle as a load uses the freshly presented period
    assign w_start_period = load_i ? period_i : r_period;

    // Start is accepted from IDLE, or in RUN unless stop overrides it
    assign w_start_acc = start_i && ((r_state == IDLE) || !stop_i);

    // Period register: reloaded from period_i in any state
    always_ff @(posedge clk_i) begin
        if (rst_i)
            r_period <= RST_PERIOD;
        else if (load_i)
            r_period <= period_i;
    end

    // Control FSM: state and latched mode
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= IDLE;
            r_mode  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start_i) begin
                        r_state <= RUN;
                        r_mode  <= mode_i;
                    end
                end
                RUN: begin
                    if (stop_i)
                        r_state <= IDLE;
                    else if (start_i)
                        r_mode  <= mode_i;
                    else if (w_zero && r_mode)
                        r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Counter steering; the periodic reload uses the stored period, so a
    // load during RUN only affects the following interval
    always_comb begin
        w_cnt_load = 1'b0;
        w_cnt_dec  = 1'b0;
        w_cnt_val  = r_period;
        if (w_start_acc) begin
            w_cnt_load = 1'b1;
            w_cnt_val  = w_start_period;
        end else if (r_state == RUN && !stop_i) begin
            if (w_zero)
                w_cnt_load = !r_mode;
            else
                w_cnt_dec  = 1'b1;
        end
    end

    tick_timer_cnt #(.n(n)) u_cnt (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .i_load     (w_cnt_load),
        .i_dec      (w_cnt_dec),
        .i_load_val (w_cnt_val),
        .o_count    (w_count),
        .o_zero     (w_zero)
    );

    // Outputs depend only on registered state
    assign tick_o  = (r_state == RUN) && w_zero;
    assign busy_o  = (r_state == RUN);
    assign count_o = w_count;

`ifdef TICK_TIMER_TICKCNT_EN
    logic [TICK_CNT_W-1:0] r_tick_cnt;

    // Saturating count of ticks since the last accepted start
    always_ff @(posedge clk_i) begin
        if (rst_i || w_start_acc)
            r_tick_cnt <= '0;
        else if (tick_o && (r_tick_cnt != {TICK_CNT_W{1'b1}}))
            r_tick_cnt <= r_tick_cnt + 1'b1;
    end

    assign tick_cnt_o = r_tick_cnt;
`endif

endmodule

// File: tb/tb_tick_timer_n.sv
// Self-checking bench for tick_timer_n: vector table plus long-interval sequences.
module tb_tick_timer_n;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b0;
    logic       load_i = 1'b0;
    logic [4:0] period_i = '0;
    logic       start_i = 1'b0;
    logic       stop_i = 1'b0;
    logic       mode_i = 1'b0;
    logic       tick_o;
    logic       busy_o;
    logic [4:0] count_o;
`ifdef TICK_TIMER_TICKCNT_EN
    logic [7:0] tick_cnt_o;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    tick_timer_n #(.n(5), .RST_PERIOD(5'd31)) dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .load_i   (load_i),
        .period_i (period_i),
        .start_i  (start_i),
        .stop_i   (stop_i),
        .mode_i   (mode_i),
        .tick_o   (tick_o),
        .busy_o   (busy_o),
`ifdef TICK_TIMER_TICKCNT_EN
        .tick_cnt_o (tick_cnt_o),
`endif
        .count_o  (count_o)
    );

    typedef struct {
        logic       rst, load;
        logic [4:0] per;
        logic       start, stop, mode;
        logic       t, b;
        logic [4:0] c;
    } vec_t;

    vec_t tbl[33];

    function automatic vec_t mk(input logic rst, input logic load, input logic [4:0] per,
                                input logic start, input logic stop, input logic mode,
                                input logic t, input logic b, input logic [4:0] c);
        vec_t v;
        v.rst = rst; v.load = load; v.per = per; v.start = start; v.stop = stop;
        v.mode = mode; v.t = t; v.b = b; v.c = c;
        return v;
    endfunction

    // Apply one set of inputs across one rising edge, then release them
    task automatic cyc(input logic rst, input logic load, input logic [4:0] per,
                       input logic start, input logic stop, input logic mode);
        rst_i = rst; load_i = load; period_i = per;
        start_i = start; stop_i = stop; mode_i = mode;
        @(posedge clk_i);
        #1;
        rst_i = 0; load_i = 0; start_i = 0; stop_i = 0; mode_i = 0;
    endtask

    task automatic chk(input string name, input logic t, input logic b, input logic [4:0] c);
        checks++;
        if (tick_o !== t || busy_o !== b || count_o !== c) begin
            errors++;
            $display("FAIL %s: got tick=%0b busy=%0b count=%0d, want tick=%0b busy=%0b count=%0d",
                     name, tick_o, busy_o, count_o, t, b, c);
        end
    endtask

`ifdef TICK_TIMER_TICKCNT_EN
    task automatic chk_tc(input string name, input logic [7:0] e);
        checks++;
        if (tick_cnt_o !== e) begin
            errors++;
            $display("FAIL %s: got tick_cnt=%0d, want %0d", name, tick_cnt_o, e);
        end
    endtask
`endif

    initial begin
        //             rst load per start stop mode   t  b  c
        tbl[0]  = mk(1, 0, 0, 0, 0, 0,   0, 0, 0);   // reset
        tbl[1]  = mk(0, 1, 3, 0, 0, 0,   0, 0, 0);   // load 3 in IDLE
        tbl[2]  = mk(0, 0, 0, 1, 0, 1,   0, 1, 3);   // one-shot start
        tbl[3]  = mk(0, 0, 0, 0, 0, 0,   0, 1, 2);
        tbl[4]  = mk(0, 0, 0, 0, 0, 0,   0, 1, 1);
        tbl[5]  = mk(0, 0, 0, 0, 0, 0,   1, 1, 0);   // tick at start+4
        tbl[6]  = mk(0, 0, 0, 0, 0, 0,   0, 0, 0);   // back to IDLE
        tbl[7]  = mk(0, 0, 0, 0, 0, 0,   0, 0, 0);
        tbl[8]  = mk(0, 1, 0, 1, 0, 0,   1, 1, 0);   // load 0 + periodic start
        tbl[9]  = mk(0, 0, 0, 0, 0, 0,   1, 1, 0);
        tbl[10] = mk(0, 0, 0, 0, 0, 0,   1, 1, 0);
        tbl[11] = mk(0, 0, 0, 0, 1, 0,   0, 0, 0);   // stop
        tbl[12] = mk(0, 0, 0, 0, 0, 0,   0, 0, 0);
        tbl[13] = mk(0, 1, 2, 1, 0, 0,   0, 1, 2);
        tbl[14] = mk(0, 0, 0, 0, 0, 0,   0, 1, 1);
        tbl[15] = mk(0, 0, 0, 1, 1, 0,   0, 0, 1);   // stop beats start
        tbl[16] = mk(0, 0, 0, 0, 0, 0,   0, 0, 1);
        tbl[17] = mk(0, 1, 5, 1, 0, 0,   0, 1, 5);   // load 5 + start
        tbl[18] = mk(0, 0, 0, 0, 0, 0,   0, 1, 4);
        tbl[19] = mk(0, 0, 0, 0, 0, 0,   0, 1, 3);
        tbl[20] = mk(0, 0, 0, 0, 0, 0,   0, 1, 2);
        tbl[21] = mk(0, 0, 0, 0, 0, 0,   0, 1, 1);
        tbl[22] = mk(0, 0, 0, 0, 0, 0,   1, 1, 0);   // tick at start+6
        tbl[23] = mk(0, 0, 0, 0, 0, 0,   0, 1, 5);   // periodic reload
        tbl[24] = mk(0, 1, 2, 0, 0, 0,   0, 1, 4);   // load in RUN: deferred
        tbl[25] = mk(0, 0, 0, 0, 0, 0,   0, 1, 3);
        tbl[26] = mk(0, 0, 0, 0, 0, 0,   0, 1, 2);
        tbl[27] = mk(0, 0, 0, 0, 0, 0,   0, 1, 1);
        tbl[28] = mk(0, 0, 0, 0, 0, 0,   1, 1, 0);
        tbl[29] = mk(0, 0, 0, 0, 0, 0,   0, 1, 2);   // reload picks up 2
        tbl[30] = mk(0, 0, 0, 0, 0, 0,   0, 1, 1);
        tbl[31] = mk(0, 0, 0, 0, 0, 0,   1, 1, 0);
        tbl[32] = mk(0, 0, 0, 0, 0, 0,   0, 1, 2);

        @(negedge clk_i);
        for (int i = 0; i < 33; i++) begin
            cyc(tbl[i].rst, tbl[i].load, tbl[i].per, tbl[i].start, tbl[i].stop, tbl[i].mode);
            chk($sformatf("vec%0d", i), tbl[i].t, tbl[i].b, tbl[i].c);
        end

        // Default period after reset: ticks at start+32, +64, +96
        cyc(1, 0, 0, 0, 0, 0);
        chk("rst_default", 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 0);
        chk("p31_k1", 0, 1, 31);
        for (int k = 2; k <= 96; k++) begin
            automatic logic [4:0] e = 5'(31 - ((k - 1) % 32));
            cyc(0, 0, 0, 0, 0, 0);
            chk($sformatf("p31_k%0d", k), (e == 0), 1, e);
        end
        cyc(0, 0, 0, 0, 0, 0);
        chk("p31_k97", 0, 1, 31);
`ifdef TICK_TIMER_TICKCNT_EN
        chk_tc("tickcnt_3", 8'd3);
        cyc(0, 0, 0, 1, 0, 0);
        chk_tc("tickcnt_clr", 8'd0);
`endif

        // P=20: stop at count 10 holds it, restart resumes every 21 cycles
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 1, 20, 1, 0, 0);
        chk("p20_k1", 0, 1, 20);
        for (int k = 2; k <= 11; k++) cyc(0, 0, 0, 0, 0, 0);
        chk("p20_k11", 0, 1, 10);
        cyc(0, 0, 0, 0, 1, 0);
        chk("p20_stop", 0, 0, 10);
        cyc(0, 0, 0, 0, 0, 0);
        chk("p20_hold", 0, 0, 10);
        cyc(0, 0, 0, 1, 0, 0);
        chk("p20_re_k1", 0, 1, 20);
        for (int k = 2; k <= 43; k++) begin
            automatic logic [4:0] e = 5'(20 - ((k - 1) % 21));
            cyc(0, 0, 0, 0, 0, 0);
            chk($sformatf("p20_re_k%0d", k), (e == 0), 1, e);
        end

        // Mid-run reset restores the default period
        cyc(0, 1, 12, 1, 0, 0);
        chk("p12_k1", 0, 1, 12);
        for (int k = 2; k <= 6; k++) cyc(0, 0, 0, 0, 0, 0);
        chk("p12_k6", 0, 1, 7);
        cyc(1, 0, 0, 0, 0, 0);
        chk("midrun_rst", 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 0);
        chk("after_rst_k1", 0, 1, 31);
        for (int k = 2; k <= 31; k++) cyc(0, 0, 0, 0, 0, 0);
        chk("after_rst_k31", 0, 1, 1);
        cyc(0, 0, 0, 0, 0, 0);
        chk("after_rst_k32", 1, 1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
